// File: rtl/stream_upsizer.sv
// Narrow-to-wide valid/ready stream packer: RATIO input beats form one output word,
// with an early partial-word flush (and per-lane keep mask) when a beat carries last.
module stream_upsizer #(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_last_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [RATIO-1:0]     out_keep_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ACC_LANES = (RATIO > 1) ? RATIO - 1 : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  if (RATIO < 1) begin : g_ratio_check
    $error("stream_upsizer: RATIO must be >= 1");
  end
  if (IN_WIDTH < 1) begin : g_width_check
    $error("stream_upsizer: IN_WIDTH must be >= 1");
  end

  logic [CW-1:0]                      r_cnt;
  logic [ACC_LANES-1:0][IN_WIDTH-1:0] r_acc_data;
  logic [ACC_LANES-1:0]               r_acc_keep;
  logic [OUT_WIDTH-1:0]               r_out_data;
  logic [RATIO-1:0]                   r_out_keep;
  logic                               r_out_last;
  logic                               r_out_valid;

  logic                 w_in_ready;
  logic                 w_acc_hs;
  logic                 w_complete;
  logic [OUT_WIDTH-1:0] w_word;
  logic [RATIO-1:0]     w_keep;

  // The output register can take a new word whenever it is empty or being drained.
  assign w_in_ready = ~r_out_valid | out_ready_i;
  assign w_acc_hs   = in_valid_i & w_in_ready;
  assign w_complete = w_acc_hs & ((r_cnt == LAST_LANE) | in_last_i);

  // Lanes below cnt come from the accumulator (gated by their keep bit), lane cnt
  // takes the incoming beat, and everything above is zero with keep cleared.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(gi);
    if (gi < RATIO - 1) begin : g_acc_lane
      assign w_word[gi*IN_WIDTH +: IN_WIDTH] = (r_cnt == LANE) ? in_data_i :
                                               (r_acc_keep[gi] ? r_acc_data[gi] : '0);
      assign w_keep[gi] = (r_cnt == LANE) | r_acc_keep[gi];
    end else begin : g_top_lane
      assign w_word[gi*IN_WIDTH +: IN_WIDTH] = (r_cnt == LANE) ? in_data_i : '0;
      assign w_keep[gi] = (r_cnt == LANE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_acc_data  <= '0;
      r_acc_keep  <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_complete) begin
      r_out_data  <= w_word;
      r_out_keep  <= w_keep;
      r_out_last  <= in_last_i;
      r_out_valid <= 1'b1;
      r_cnt       <= '0;
      r_acc_keep  <= '0;
    end else begin
      if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_acc_hs) begin
        r_cnt <= r_cnt + CW'(1);
        for (int i = 0; i < ACC_LANES; i++) begin
          if (r_cnt == CW'(i)) begin
            r_acc_data[i] <= in_data_i;
            r_acc_keep[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_data_o  = r_out_data;
  assign out_keep_o  = r_out_keep;
  assign out_last_o  = r_out_last;
  assign out_valid_o = r_out_valid;

endmodule
